accum_frame_buffer: RTL and testbench

ACCUM_FRAME_BUFFER -- requirements
Module: accum_frame_buffer

---
 rtl/accum_frame_buffer_if.sv | 35 +++
 rtl/accum_frame_buffer.sv | 185 ++++++++++++++++++
 tb/tb_accum_frame_buffer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_frame_buffer_if.sv
// Bus bundle for accum_frame_buffer: write-sample handshake, frame-clear control and display read port.
// The master side drives requests and the slave side (the frame buffer) answers.
interface accum_frame_buffer_if #(
   parameter int CHANNELS = 3,
   parameter int CH_WIDTH = 8,
   parameter int SHIFT_W  = 3
);
   logic [10:0]                  pixel_h;
   logic [9:0]                   pixel_v;
   logic [CHANNELS*CH_WIDTH-1:0] new_color;
   logic                         new_color_valid;
   logic                         new_color_ready;
   logic [SHIFT_W-1:0]           blend_shift;
   logic                         clear_req;
   logic                         clear_busy;
   logic [10:0]                  rd_h;
   logic [9:0]                   rd_v;
   logic                         rd_valid;
   logic [CHANNELS*CH_WIDTH-1:0] rd_color;
   logic                         rd_color_valid;
   logic [10:0]                  rd_h_out;
   logic [9:0]                   rd_v_out;

   modport master (
      output pixel_h, pixel_v, new_color, new_color_valid, blend_shift,
      output clear_req, rd_h, rd_v, rd_valid,
      input  new_color_ready, clear_busy, rd_color, rd_color_valid, rd_h_out, rd_v_out
   );

   modport slave (
      input  pixel_h, pixel_v, new_color, new_color_valid, blend_shift,
      input  clear_req, rd_h, rd_v, rd_valid,
      output new_color_ready, clear_busy, rd_color, rd_color_valid, rd_h_out, rd_v_out
   );
endinterface

// File: rtl/accum_frame_buffer.sv
// Accumulating frame buffer: each accepted sample is blended into its pixel through a 4-stage
// read-modify-write pipeline; includes a drain-then-sweep frame clear and an independent read port.
module accum_frame_buffer #(
   parameter int SIZE_H   = 320,
   parameter int SIZE_V   = 180,
   parameter int CHANNELS = 3,
   parameter int CH_WIDTH = 8,
   parameter int SHIFT_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   accum_frame_buffer_if.slave  bus
);
   localparam int NPIX    = SIZE_H * SIZE_V;
   localparam int ADDR_W  = $clog2(NPIX);
   localparam int COLOR_W = CHANNELS * CH_WIDTH;
   localparam logic [10:0]       H_LIM     = 11'(SIZE_H);
   localparam logic [9:0]        V_LIM     = 10'(SIZE_V);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} clr_state_t;

   typedef struct packed {
      logic               valid;
      logic               in_range;
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] color;
      logic [SHIFT_W-1:0] shift;
   } wr_stage_t;

   typedef struct packed {
      logic               valid;
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] data;
   } wr_hist_t;

   typedef struct packed {
      logic        valid;
      logic        in_range;
      logic [10:0] h;
      logic [9:0]  v;
   } rd_stage_t;

   logic [COLOR_W-1:0] mem [NPIX];

   clr_state_t         state_q, state_d;
   logic               ready_en_q;
   logic [ADDR_W-1:0]  sweep_addr_q, sweep_addr_d;
   wr_stage_t          s1_q, s1_d, s2_q, s3_q;
   wr_hist_t           hist1_q, hist1_d, hist2_q, hist3_q;
   logic [COLOR_W-1:0] old1_q, old2_q, old3_q, old_fwd;
   rd_stage_t          r1_q, r1_d;
   logic [COLOR_W-1:0] rd_mem_q;
   logic [COLOR_W-1:0] rd_color_q, rd_color_d;
   logic               rd_color_valid_q, rd_color_valid_d;
   logic [10:0]        rd_h_out_q, rd_h_out_d;
   logic [9:0]         rd_v_out_q, rd_v_out_d;
   logic               ready, accept, acc_in_range, rd_in_range;
   logic [ADDR_W-1:0]  acc_addr, rd_addr;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [10:0] h, input logic [9:0] v);
      return ADDR_W'(h) + ADDR_W'(v) * ADDR_W'(SIZE_H);
   endfunction

   // Per channel old + ((new - old) >>> k); the sum is widened so the clamp sees sign and carry
   function automatic logic [COLOR_W-1:0] blend(input logic [COLOR_W-1:0] old_c,
                                                input logic [COLOR_W-1:0] new_c,
                                                input logic [SHIFT_W-1:0] k);
      logic [COLOR_W-1:0]        res;
      logic signed [CH_WIDTH:0]   diff;
      logic signed [CH_WIDTH:0]   step;
      logic signed [CH_WIDTH+1:0] sum;
      res = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         diff = $signed({1'b0, new_c[c*CH_WIDTH +: CH_WIDTH]}) - $signed({1'b0, old_c[c*CH_WIDTH +: CH_WIDTH]});
         step = diff >>> k;
         sum  = $signed({2'b00, old_c[c*CH_WIDTH +: CH_WIDTH]}) + $signed({step[CH_WIDTH], step});
         if (sum[CH_WIDTH+1])
            res[c*CH_WIDTH +: CH_WIDTH] = '0;
         else if (sum[CH_WIDTH])
            res[c*CH_WIDTH +: CH_WIDTH] = '1;
         else
            res[c*CH_WIDTH +: CH_WIDTH] = sum[CH_WIDTH-1:0];
      end
      return res;
   endfunction

   always_comb begin
      acc_in_range = (bus.pixel_h < H_LIM) && (bus.pixel_v < V_LIM);
      acc_addr     = acc_in_range ? pix_addr(bus.pixel_h, bus.pixel_v) : '0;
      ready        = ready_en_q && (state_q == IDLE) && !bus.clear_req;
      accept       = bus.new_color_valid && ready;
      s1_d         = '{valid: accept, in_range: acc_in_range, addr: acc_addr,
                       color: bus.new_color, shift: bus.blend_shift};
   end

   // The BRAM read at acceptance misses the three writes that land while the sample is in flight;
   // those are kept in hist1..hist3 and the youngest matching one overrides the stale data.
   always_comb begin
      old_fwd = old3_q;
      if (hist3_q.valid && hist3_q.addr == s3_q.addr) old_fwd = hist3_q.data;
      if (hist2_q.valid && hist2_q.addr == s3_q.addr) old_fwd = hist2_q.data;
      if (hist1_q.valid && hist1_q.addr == s3_q.addr) old_fwd = hist1_q.data;
      if (state_q == SWEEP)
         hist1_d = '{valid: 1'b1, addr: sweep_addr_q, data: '0};
      else
         hist1_d = '{valid: s3_q.valid && s3_q.in_range, addr: s3_q.addr,
                     data: blend(old_fwd, s3_q.color, s3_q.shift)};
   end

   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      case (state_q)
         IDLE:  if (bus.clear_req) state_d = DRAIN;
         DRAIN: if (!(s1_q.valid || s2_q.valid || s3_q.valid)) begin
                   state_d      = SWEEP;
                   sweep_addr_d = '0;
                end
         SWEEP: if (sweep_addr_q == LAST_ADDR) state_d = IDLE;
                else sweep_addr_d = sweep_addr_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_in_range      = (bus.rd_h < H_LIM) && (bus.rd_v < V_LIM);
      rd_addr          = rd_in_range ? pix_addr(bus.rd_h, bus.rd_v) : '0;
      r1_d             = '{valid: bus.rd_valid, in_range: rd_in_range, h: bus.rd_h, v: bus.rd_v};
      rd_color_d       = r1_q.in_range ? rd_mem_q : '0;
      rd_color_valid_d = r1_q.valid;
      rd_h_out_d       = r1_q.h;
      rd_v_out_d       = r1_q.v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         ready_en_q       <= 1'b0;
         sweep_addr_q     <= '0;
         s1_q             <= '0;
         s2_q             <= '0;
         s3_q             <= '0;
         hist1_q          <= '0;
         hist2_q          <= '0;
         hist3_q          <= '0;
         r1_q             <= '0;
         rd_color_q       <= '0;
         rd_color_valid_q <= 1'b0;
         rd_h_out_q       <= '0;
         rd_v_out_q       <= '0;
      end else begin
         state_q          <= state_d;
         ready_en_q       <= 1'b1;
         sweep_addr_q     <= sweep_addr_d;
         s1_q             <= s1_d;
         s2_q             <= s1_q;
         s3_q             <= s2_q;
         hist1_q          <= hist1_d;
         hist2_q          <= hist1_q;
         hist3_q          <= hist2_q;
         r1_q             <= r1_d;
         rd_color_q       <= rd_color_d;
         rd_color_valid_q <= rd_color_valid_d;
         rd_h_out_q       <= rd_h_out_d;
         rd_v_out_q       <= rd_v_out_d;
      end
   end

   // Memory and its output registers are not reset so pixel contents survive rst
   always_ff @(posedge clk) begin
      if (hist1_d.valid) mem[hist1_d.addr] <= hist1_d.data;
      old1_q   <= mem[acc_addr];
      old2_q   <= old1_q;
      old3_q   <= old2_q;
      rd_mem_q <= mem[rd_addr];
   end

   assign bus.new_color_ready = ready;
   assign bus.clear_busy      = (state_q != IDLE);
   assign bus.rd_color        = rd_color_q;
   assign bus.rd_color_valid  = rd_color_valid_q;
   assign bus.rd_h_out        = rd_h_out_q;
   assign bus.rd_v_out        = rd_v_out_q;
endmodule

// File: tb/tb_accum_frame_buffer.sv
// Self-checking bench for accum_frame_buffer: table-driven blend vectors, a read scoreboard,
// and hand-written sequences for hazards, frame clear and reset behaviour.
module tb_accum_frame_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   accum_frame_buffer_if #(.CHANNELS(3), .CH_WIDTH(8), .SHIFT_W(3)) bus ();

   accum_frame_buffer #(
      .SIZE_H(320), .SIZE_V(180), .CHANNELS(3), .CH_WIDTH(8), .SHIFT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int          h;
      int          v;
      logic [23:0] color;
      int          k;
      logic [23:0] exp_read;
   } vec_t;

   typedef struct {
      logic [23:0] color;
      int          h;
      int          v;
      int          issue;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   rd_exp_t     mon_e;
   vec_t        vecs[10];
   logic [23:0] model[int];
   int          rnd_h[3];
   int          rnd_v[3];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called on a negedge; holds the sample for one edge and returns on the following negedge
   task automatic applyStimulus(input int h, input int v, input logic [23:0] c, input int k);
      bus.pixel_h         = 11'(h);
      bus.pixel_v         = 10'(v);
      bus.new_color       = c;
      bus.blend_shift     = 3'(k);
      bus.new_color_valid = 1'b1;
      @(negedge clk);
      bus.new_color_valid = 1'b0;
   endtask

   task automatic readRequest(input int h, input int v, input logic [23:0] exp);
      bus.rd_h     = 11'(h);
      bus.rd_v     = 10'(v);
      bus.rd_valid = 1'b1;
      rd_q.push_back('{color: exp, h: h, v: v, issue: cyc});
      @(negedge clk);
      bus.rd_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   function automatic logic [23:0] blendRef(input logic [23:0] o, input logic [23:0] n, input int k);
      logic [23:0] r;
      int ov, nv, d, s;
      r = '0;
      for (int ch = 0; ch < 3; ch++) begin
         ov = int'(o[ch*8 +: 8]);
         nv = int'(n[ch*8 +: 8]);
         d  = nv - ov;
         if (d >= 0) s = d / (1 << k);
         else        s = -((-d + (1 << k) - 1) / (1 << k));
         r[ch*8 +: 8] = 8'(ov + s);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (bus.rd_color_valid) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rd_valid actual=1 required=0 (t=%0t)", $time);
         end else begin
            mon_e = rd_q.pop_front();
            checkOutput("rd_color", 32'(bus.rd_color), 32'(mon_e.color));
            checkOutput("rd_h_out", 32'(bus.rd_h_out), 32'(mon_e.h));
            checkOutput("rd_v_out", 32'(bus.rd_v_out), 32'(mon_e.v));
            checkOutput("rd_latency", 32'(cyc - mon_e.issue), 32'd2);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busy_cycles;
      int ready_high;
      int idx;
      logic [23:0] c;
      int k;

      vecs[0] = '{h: 5,   v: 2,   color: 24'h646464, k: 0, exp_read: 24'h646464};
      vecs[1] = '{h: 5,   v: 2,   color: 24'hC8C8C8, k: 3, exp_read: 24'h707070};
      vecs[2] = '{h: 6,   v: 2,   color: 24'hC8C8C8, k: 0, exp_read: 24'hC8C8C8};
      vecs[3] = '{h: 6,   v: 2,   color: 24'h646464, k: 3, exp_read: 24'hBBBBBB};
      vecs[4] = '{h: 7,   v: 2,   color: 24'h123456, k: 0, exp_read: 24'h123456};
      vecs[5] = '{h: 8,   v: 3,   color: 24'h00FF10, k: 0, exp_read: 24'h00FF10};
      vecs[6] = '{h: 8,   v: 3,   color: 24'hFF0020, k: 2, exp_read: 24'h3FBF14};
      vecs[7] = '{h: 319, v: 179, color: 24'hABCDEF, k: 0, exp_read: 24'hABCDEF};
      vecs[8] = '{h: 10,  v: 10,  color: 24'h010203, k: 0, exp_read: 24'h010203};
      vecs[9] = '{h: 0,   v: 1,   color: 24'h0A0B0C, k: 0, exp_read: 24'h0A0B0C};

      bus.pixel_h = '0; bus.pixel_v = '0; bus.new_color = '0; bus.new_color_valid = 1'b0;
      bus.blend_shift = '0; bus.clear_req = 1'b0; bus.rd_h = '0; bus.rd_v = '0; bus.rd_valid = 1'b0;

      idleCycles(3);
      checkOutput("reset_ready", 32'(bus.new_color_ready), 32'd0);
      checkOutput("reset_busy", 32'(bus.clear_busy), 32'd0);
      checkOutput("reset_rd_valid", 32'(bus.rd_color_valid), 32'd0);
      checkOutput("reset_rd_color", 32'(bus.rd_color), 32'd0);
      checkOutput("reset_rd_h_out", 32'(bus.rd_h_out), 32'd0);
      checkOutput("reset_rd_v_out", 32'(bus.rd_v_out), 32'd0);
      rst = 1'b0;
      #1 checkOutput("ready_before_edge", 32'(bus.new_color_ready), 32'd0);
      @(posedge clk);
      #1 checkOutput("ready_after_edge", 32'(bus.new_color_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].h, vecs[i].v, vecs[i].color, vecs[i].k);
         idleCycles(4);
         readRequest(vecs[i].h, vecs[i].v, vecs[i].exp_read);
      end
      idleCycles(3);

      // Back-to-back same-address samples versus the same sequence spaced apart
      applyStimulus(0, 0, 24'h000000, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 24'hFFFFFF, 1);
      applyStimulus(1, 0, 24'h000000, 0);
      idleCycles(4);
      applyStimulus(1, 0, 24'hFFFFFF, 1);
      idleCycles(4);
      readRequest(1, 0, 24'h7F7F7F);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 24'hFFFFFF, 1);
         idleCycles(4);
      end
      readRequest(0, 0, 24'hEFEFEF);
      readRequest(1, 0, 24'hEFEFEF);

      // Out-of-range write at (320,0) would alias pixel (0,1) if not discarded
      bus.pixel_h = 11'd320; bus.pixel_v = 10'd0; bus.new_color = 24'hFFFFFF;
      bus.blend_shift = 3'd0; bus.new_color_valid = 1'b1;
      #1 checkOutput("ready_oor", 32'(bus.new_color_ready), 32'd1);
      @(negedge clk);
      bus.new_color_valid = 1'b0;
      checkOutput("ready_after_oor", 32'(bus.new_color_ready), 32'd1);
      idleCycles(4);
      readRequest(0, 1, 24'h0A0B0C);
      readRequest(320, 0, 24'h000000);
      readRequest(10, 180, 24'h000000);
      readRequest(5, 2, 24'h707070);

      // Read in the same cycle as the write returns the pre-write value
      applyStimulus(7, 2, 24'h654321, 0);
      idleCycles(2);
      readRequest(7, 2, 24'h123456);
      readRequest(7, 2, 24'h654321);
      idleCycles(3);

      // Random back-to-back samples over three neighbouring pixels against a serial model
      rnd_h = '{20, 21, 20};
      rnd_v = '{5, 5, 6};
      for (int i = 0; i < 3; i++) begin
         c = 24'($urandom);
         model[i] = c;
         applyStimulus(rnd_h[i], rnd_v[i], c, 0);
      end
      for (int i = 0; i < 24; i++) begin
         idx = $urandom_range(0, 2);
         c = 24'($urandom);
         k = $urandom_range(0, 7);
         model[idx] = blendRef(model[idx], c, k);
         applyStimulus(rnd_h[idx], rnd_v[idx], c, k);
      end
      idleCycles(4);
      for (int i = 0; i < 3; i++) readRequest(rnd_h[i], rnd_v[i], model[i]);
      idleCycles(3);

      // Frame clear with two samples still in flight; a second clear_req mid-sweep is ignored
      applyStimulus(9, 0, 24'h111111, 0);
      applyStimulus(9, 1, 24'h222222, 0);
      bus.clear_req = 1'b1;
      #1 checkOutput("ready_on_clear_req", 32'(bus.new_color_ready), 32'd0);
      @(negedge clk);
      bus.clear_req = 1'b0;
      busy_cycles = 0;
      ready_high = 0;
      for (int i = 0; i < 70000; i++) begin
         if (!bus.clear_busy) break;
         busy_cycles++;
         if (bus.new_color_ready) ready_high++;
         bus.clear_req = (i == 100);
         @(negedge clk);
      end
      bus.clear_req = 1'b0;
      checkOutput("clear_busy_done", 32'(bus.clear_busy), 32'd0);
      checkOutput("clear_busy_cycles", 32'(busy_cycles), 32'd57603);
      checkOutput("ready_during_clear", 32'(ready_high), 32'd0);
      checkOutput("ready_after_clear", 32'(bus.new_color_ready), 32'd1);
      readRequest(9, 0, 24'h0);
      readRequest(9, 1, 24'h0);
      readRequest(5, 2, 24'h0);
      readRequest(319, 179, 24'h0);
      readRequest(0, 0, 24'h0);

      // Reset in the middle of a sweep aborts it: low pixels cleared, high pixels kept
      applyStimulus(300, 170, 24'h555555, 0);
      applyStimulus(4, 0, 24'h222222, 0);
      idleCycles(4);
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      idleCycles(200);
      checkOutput("busy_mid_sweep", 32'(bus.clear_busy), 32'd1);
      #2 rst = 1'b1;
      #1 checkOutput("rst_busy", 32'(bus.clear_busy), 32'd0);
      checkOutput("rst_ready", 32'(bus.new_color_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("ready_before_edge2", 32'(bus.new_color_ready), 32'd0);
      @(posedge clk);
      #1 checkOutput("ready_after_edge2", 32'(bus.new_color_ready), 32'd1);
      @(negedge clk);
      readRequest(300, 170, 24'h555555);
      readRequest(4, 0, 24'h000000);

      // Reset with a sample in flight loses the sample
      applyStimulus(300, 170, 24'h111111, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idleCycles(5);
      readRequest(300, 170, 24'h555555);
      idleCycles(3);

      // Reset clears read outputs immediately (response deliberately not on the scoreboard)
      bus.rd_h = 11'd300; bus.rd_v = 10'd170; bus.rd_valid = 1'b1;
      @(negedge clk);
      bus.rd_valid = 1'b0;
      @(posedge clk);
      #1 checkOutput("rd_valid_before_rst", 32'(bus.rd_color_valid), 32'd1);
      checkOutput("rd_color_before_rst", 32'(bus.rd_color), 32'h555555);
      #1 rst = 1'b1;
      #1 checkOutput("rst_rd_valid", 32'(bus.rd_color_valid), 32'd0);
      checkOutput("rst_rd_color", 32'(bus.rd_color), 32'd0);
      checkOutput("rst_rd_h_out", 32'(bus.rd_h_out), 32'd0);
      checkOutput("rst_rd_v_out", 32'(bus.rd_v_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idleCycles(4);

      checkOutput("scoreboard_empty", 32'(rd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
